// File: rtl/pc_pkg.sv
// Shared encodings for the program counter / return-stack block.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SRC_IMMED = 2'b00,
        PC_SRC_STACK = 2'b01,
        PC_SRC_INTR  = 2'b10,
        PC_SRC_RESET = 2'b11
    } pc_src_t;

    typedef enum logic {
        PUSH_NEXT = 1'b0,
        PUSH_CUR  = 1'b1
    } push_src_t;

endpackage

// File: rtl/return_lifo.sv
// Register-array return-address LIFO with combinational top read and
// single-cycle overflow/underflow pulses.
module return_lifo #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 8,
    localparam int CW         = $clog2(STACK_DEPTH + 1),
    localparam int IW         = $clog2(STACK_DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PUSH,
    input  logic              POP,
    input  logic [ADDR_W-1:0] DIN,
    output logic [ADDR_W-1:0] TOP,
    output logic [CW-1:0]     CNT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              OVF,
    output logic              UNF
);

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [ADDR_W-1:0] mem_d [STACK_DEPTH];
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     wr_idx, top_idx;

    assign CNT   = cnt_q;
    assign FULL  = (cnt_q == CW'(STACK_DEPTH));
    assign EMPTY = (cnt_q == '0);

    always_comb begin
        TOP = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (CW'(i + 1) == cnt_q) TOP = mem_q[i];
        end
    end

    always_comb begin
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        OVF     = 1'b0;
        UNF     = 1'b0;
        wr_idx  = IW'(cnt_q);
        top_idx = IW'(cnt_q - CW'(1));
        if (PUSH && POP && !EMPTY) begin
            // Replace-top: net occupancy unchanged, never an error.
            mem_d[top_idx] = DIN;
        end else if (PUSH) begin
            if (FULL) begin
                OVF = 1'b1;
            end else begin
                mem_d[wr_idx] = DIN;
                cnt_d         = cnt_q + CW'(1);
            end
            if (POP) UNF = 1'b1;
        end else if (POP) begin
            if (EMPTY) UNF = 1'b1;
            else       cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/pc_return_stack.sv
// Program counter with next-address mux, integrated return-address LIFO
// and sticky stack error flag.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 10,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] INTR_VECTOR = '1,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    localparam int               CW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PC_LD,
    input  logic              PC_INC,
    input  logic [1:0]        PC_MUX_SEL,
    input  logic [ADDR_W-1:0] FROM_IMMED,
    input  logic              PUSH,
    input  logic              PUSH_SEL,
    input  logic              POP,
    output logic [ADDR_W-1:0] PC_COUNT,
    output logic [ADDR_W-1:0] STACK_TOP,
    output logic [CW-1:0]     STACK_CNT,
    output logic              STACK_FULL,
    output logic              STACK_EMPTY,
    output logic              STACK_ERR
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus1, push_val;
    logic              err_q, err_d;
    logic              ovf, unf;

    assign PC_COUNT  = pc_q;
    assign STACK_ERR = err_q;
    assign pc_plus1  = pc_q + ADDR_W'(1);
    assign push_val  = (push_src_t'(PUSH_SEL) == PUSH_CUR) ? pc_q : pc_plus1;

    return_lifo #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .CLK   (CLK),
        .RST   (RST),
        .PUSH  (PUSH),
        .POP   (POP),
        .DIN   (push_val),
        .TOP   (STACK_TOP),
        .CNT   (STACK_CNT),
        .FULL  (STACK_FULL),
        .EMPTY (STACK_EMPTY),
        .OVF   (ovf),
        .UNF   (unf)
    );

    // STACK_TOP is the pre-pop value, so RET is a single-cycle load+pop.
    always_comb begin
        pc_d  = pc_q;
        err_d = err_q | ovf | unf;
        if (PC_LD) begin
            case (pc_src_t'(PC_MUX_SEL))
                PC_SRC_IMMED: pc_d = FROM_IMMED;
                PC_SRC_STACK: pc_d = STACK_TOP;
                PC_SRC_INTR:  pc_d = INTR_VECTOR;
                PC_SRC_RESET: pc_d = RESET_ADDR;
                default:      pc_d = pc_q;
            endcase
        end else if (PC_INC) begin
            pc_d = pc_plus1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_q  <= RESET_ADDR;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_return_stack.sv
// Self-checking bench: directed vector table, hand-written stack corner
// sequences and randomized traffic against a queue-based reference model.
module tb_pc_return_stack;

    localparam int AW    = 10;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST, PC_LD, PC_INC, PUSH, PUSH_SEL, POP;
    logic [1:0]    PC_MUX_SEL;
    logic [AW-1:0] FROM_IMMED;
    logic [AW-1:0] PC_COUNT, STACK_TOP;
    logic [CW-1:0] STACK_CNT;
    logic          STACK_FULL, STACK_EMPTY, STACK_ERR;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_pc;
    int m_stk[$];
    bit m_err;

    pc_return_stack #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .PC_LD(PC_LD), .PC_INC(PC_INC),
        .PC_MUX_SEL(PC_MUX_SEL), .FROM_IMMED(FROM_IMMED), .PUSH(PUSH),
        .PUSH_SEL(PUSH_SEL), .POP(POP), .PC_COUNT(PC_COUNT),
        .STACK_TOP(STACK_TOP), .STACK_CNT(STACK_CNT), .STACK_FULL(STACK_FULL),
        .STACK_EMPTY(STACK_EMPTY), .STACK_ERR(STACK_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int rst, ld, inc, sel, imm, push, psel, pop;
        int e_pc, e_top, e_cnt, e_err;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input int rst, ld, inc, sel, imm, push, psel, pop);
        int top_before, next_pc, pv;
        if (rst != 0) begin
            m_pc = 0;
            m_stk.delete();
            m_err = 0;
            return;
        end
        top_before = (m_stk.size() > 0) ? m_stk[$] : 0;
        pv = (psel != 0) ? m_pc : (m_pc + 1) % (1 << AW);
        next_pc = m_pc;
        if (ld != 0) begin
            case (sel)
                0: next_pc = imm;
                1: next_pc = top_before;
                2: next_pc = (1 << AW) - 1;
                default: next_pc = 0;
            endcase
        end else if (inc != 0) begin
            next_pc = (m_pc + 1) % (1 << AW);
        end
        if (push != 0 && pop != 0 && m_stk.size() > 0) begin
            m_stk[m_stk.size() - 1] = pv;
        end else if (push != 0) begin
            if (m_stk.size() == DEPTH) m_err = 1;
            else m_stk.push_back(pv);
            if (pop != 0) m_err = 1;
        end else if (pop != 0) begin
            if (m_stk.size() == 0) m_err = 1;
            else void'(m_stk.pop_back());
        end
        m_pc = next_pc;
    endtask

    // Drive one cycle, advance the model, and compare every output to it.
    task automatic step(input int rst, ld, inc, sel, imm, push, psel, pop);
        int e_top;
        @(negedge CLK);
        RST = rst[0]; PC_LD = ld[0]; PC_INC = inc[0]; PC_MUX_SEL = sel[1:0];
        FROM_IMMED = imm[AW-1:0]; PUSH = push[0]; PUSH_SEL = psel[0]; POP = pop[0];
        @(posedge CLK);
        model_update(rst, ld, inc, sel, imm, push, psel, pop);
        #1;
        e_top = (m_stk.size() > 0) ? m_stk[$] : 0;
        chk("model_pc",    int'(PC_COUNT),    m_pc);
        chk("model_top",   int'(STACK_TOP),   e_top);
        chk("model_cnt",   int'(STACK_CNT),   m_stk.size());
        chk("model_full",  int'(STACK_FULL),  (m_stk.size() == DEPTH) ? 1 : 0);
        chk("model_empty", int'(STACK_EMPTY), (m_stk.size() == 0) ? 1 : 0);
        chk("model_err",   int'(STACK_ERR),   int'(m_err));
    endtask

    initial begin
        RST = 1; PC_LD = 0; PC_INC = 0; PC_MUX_SEL = 0; FROM_IMMED = 0;
        PUSH = 0; PUSH_SEL = 0; POP = 0;
        m_pc = 0; m_err = 0;

        //          rst ld inc sel imm    push psel pop  pc     top    cnt err
        tbl[0]  = '{1, 0, 0, 0, 0,     0, 0, 0,  0,     0,     0, 0};
        tbl[1]  = '{0, 0, 1, 0, 0,     0, 0, 0,  1,     0,     0, 0};
        tbl[2]  = '{0, 0, 1, 0, 0,     0, 0, 0,  2,     0,     0, 0};
        tbl[3]  = '{0, 0, 1, 0, 0,     0, 0, 0,  3,     0,     0, 0};
        tbl[4]  = '{0, 0, 1, 0, 0,     0, 0, 0,  4,     0,     0, 0};
        tbl[5]  = '{0, 1, 0, 0, 'h3FF, 0, 0, 0,  'h3FF, 0,     0, 0};
        tbl[6]  = '{0, 0, 1, 0, 0,     0, 0, 0,  0,     0,     0, 0};
        tbl[7]  = '{0, 1, 0, 0, 'h020, 0, 0, 0,  'h020, 0,     0, 0};
        tbl[8]  = '{0, 1, 0, 0, 'h100, 1, 0, 0,  'h100, 'h021, 1, 0};
        tbl[9]  = '{0, 1, 0, 1, 0,     0, 0, 1,  'h021, 0,     0, 0};
        tbl[10] = '{0, 1, 0, 0, 'h055, 0, 0, 0,  'h055, 0,     0, 0};
        tbl[11] = '{0, 1, 0, 2, 0,     1, 1, 0,  'h3FF, 'h055, 1, 0};
        tbl[12] = '{0, 1, 0, 0, 'h200, 1, 0, 0,  'h200, 'h000, 2, 0};
        tbl[13] = '{0, 1, 0, 1, 0,     0, 0, 1,  'h000, 'h055, 1, 0};
        tbl[14] = '{0, 1, 0, 1, 0,     0, 0, 1,  'h055, 0,     0, 0};
        tbl[15] = '{0, 1, 0, 1, 0,     0, 0, 1,  0,     0,     0, 1};
        tbl[16] = '{0, 0, 1, 0, 0,     0, 0, 0,  1,     0,     0, 1};
        tbl[17] = '{0, 1, 1, 3, 0,     0, 0, 0,  0,     0,     0, 1};
        tbl[18] = '{1, 0, 0, 0, 0,     0, 0, 0,  0,     0,     0, 0};

        for (int k = 0; k < 19; k++) begin
            step(tbl[k].rst, tbl[k].ld, tbl[k].inc, tbl[k].sel, tbl[k].imm,
                 tbl[k].push, tbl[k].psel, tbl[k].pop);
            chk($sformatf("vec%0d_pc", k),  int'(PC_COUNT),  tbl[k].e_pc);
            chk($sformatf("vec%0d_top", k), int'(STACK_TOP), tbl[k].e_top);
            chk($sformatf("vec%0d_cnt", k), int'(STACK_CNT), tbl[k].e_cnt);
            chk($sformatf("vec%0d_err", k), int'(STACK_ERR), tbl[k].e_err);
        end

        // Overflow: CALL-style pushes while incrementing push 1..9.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 1, 0, 0);
        chk("ovf_full8", int'(STACK_FULL), 1);
        chk("ovf_top8",  int'(STACK_TOP),  8);
        chk("ovf_err_before", int'(STACK_ERR), 0);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        chk("ovf_top_kept", int'(STACK_TOP), 8);
        chk("ovf_cnt_kept", int'(STACK_CNT), 8);
        chk("ovf_err_set",  int'(STACK_ERR), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lifo_pop%0d", i), int'(STACK_TOP), 8 - i);
            step(0, 0, 0, 0, 0, 0, 0, 1);
        end
        step(0, 1, 0, 1, 0, 0, 0, 1);
        chk("unf_cnt", int'(STACK_CNT), 0);
        chk("unf_top", int'(STACK_TOP), 0);
        chk("unf_pc_loads0", int'(PC_COUNT), 0);
        chk("unf_err", int'(STACK_ERR), 1);

        // Reset overrides a push/load on a non-empty stack.
        step(0, 0, 1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 'h123, 1, 0, 0);
        chk("rst_cnt", int'(STACK_CNT), 0);
        chk("rst_pc",  int'(PC_COUNT),  0);
        chk("rst_err", int'(STACK_ERR), 0);
        chk("rst_empty", int'(STACK_EMPTY), 1);

        // Simultaneous push+pop at CNT=3 replaces the top.
        step(0, 1, 0, 0, 'h0A0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 'h0B7, 1, 1, 0);
        chk("pp_cnt_pre", int'(STACK_CNT), 3);
        step(0, 0, 0, 0, 0, 1, 1, 1);
        chk("pp_cnt", int'(STACK_CNT), 3);
        chk("pp_top", int'(STACK_TOP), 'h0B7);
        chk("pp_err", int'(STACK_ERR), 0);
        // Push+pop on empty behaves as a push and flags an error.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        chk("ppe_cnt", int'(STACK_CNT), 1);
        chk("ppe_top", int'(STACK_TOP), 1);
        chk("ppe_err", int'(STACK_ERR), 1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 39) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, (1 << AW) - 1)),
                 ($urandom_range(0, 2) == 0) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Parametrised next-generation program counter for the MCU fetch path.
- Combines the PC register, the next-address mux and an integrated hardware return-address LIFO, so CALL, RET and interrupt entry no longer need an external stack path.
- Sits between the control unit (PC_LD, PC_INC, select, push/pop strobes) and program ROM (PC_COUNT).
- Adds wrap-around increment, stack occupancy/full/empty status and a sticky overflow/underflow error flag.

Parameters:
- ADDR_W, 10, width of PC and of every stored return address.
- STACK_DEPTH, 8, number of return-address entries (>=2).
- INTR_VECTOR, all ones (10'h3FF at default width), address loaded on interrupt select.
- RESET_ADDR, 0, PC value after RST and on restart select.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- PC_LD  in  1  load PC from the selected source.
- PC_INC  in  1  increment PC.
- PC_MUX_SEL  in  2  load source: 00 FROM_IMMED, 01 stack top, 10 INTR_VECTOR, 11 RESET_ADDR.
- FROM_IMMED  in  ADDR_W  branch/call target from the instruction.
- PUSH  in  1  push a return address this cycle.
- PUSH_SEL  in  1  push value: 0 = PC_COUNT+1 (CALL), 1 = PC_COUNT (interrupt entry).
- POP  in  1  pop the top entry this cycle.
- PC_COUNT  out  ADDR_W  current program address.
- STACK_TOP  out  ADDR_W  top entry; 0 when empty.
- STACK_CNT  out  $clog2(STACK_DEPTH+1)  occupied entries.
- STACK_FULL  out  1  STACK_CNT == STACK_DEPTH.
- STACK_EMPTY  out  1  STACK_CNT == 0.
- STACK_ERR  out  1  sticky overflow/underflow flag.

Behaviour:
- One clock (CLK); reset RST is synchronous and active-high.
- RST: PC_COUNT=RESET_ADDR, STACK_CNT=0, STACK_EMPTY=1, STACK_FULL=0, STACK_TOP=0, STACK_ERR=0. RST overrides all other inputs in that cycle, including a mid-operation push or pop.
- PC update, one-cycle latency at the rising edge. Priority: RST > PC_LD > PC_INC > hold.
- PC_LD with select 01 loads STACK_TOP as it stands before this cycle's pop, so RET is PC_LD + select 01 + POP in one cycle.
- PC_INC computes PC_COUNT+1 modulo 2^ADDR_W; all ones wraps to 0.
- Push value is computed from the pre-edge PC_COUNT, also modulo 2^ADDR_W.
- Stack ops are independent of PC_LD/PC_INC; the stack updates on the same edge.
  - PUSH only, not full: write entry, STACK_CNT+1.
  - PUSH only, full: entry and count unchanged, STACK_ERR set.
  - POP only, not empty: STACK_CNT-1.
  - POP only, empty: count unchanged, STACK_ERR set. A simultaneous PC_LD with select 01 loads 0.
  - PUSH and POP, not empty: top entry overwritten with the push value, count unchanged, no error.
  - PUSH and POP, empty: treated as a push, STACK_ERR set.
- STACK_TOP, STACK_FULL, STACK_EMPTY and STACK_CNT are combinational from registered state, so they are valid the cycle after the edge.
- STACK_ERR stays set until RST.
- No internal state machine beyond the PC and stack registers. Stack storage is a register array, not inferred block RAM, for same-cycle top read.

Decomposition:
- Package pc_pkg:
  - enum pc_src_t {PC_SRC_IMMED=2'b00, PC_SRC_STACK=2'b01, PC_SRC_INTR=2'b10, PC_SRC_RESET=2'b11}.
  - enum push_src_t {PUSH_NEXT=1'b0, PUSH_CUR=1'b1}.
- One sub-module: return_lifo.
  - Parameters: ADDR_W, STACK_DEPTH.
  - Ports: CLK, RST, PUSH, POP, DIN; outputs TOP, CNT, FULL, EMPTY, OVF, UNF (single-cycle pulses).
  - Top level holds the PC register, the source mux and the sticky STACK_ERR built from OVF|UNF.

Test Plan:
- Reset then 4 cycles PC_INC=1 -> PC_COUNT 0,1,2,3,4; STACK_EMPTY=1, STACK_ERR=0.
- PC_COUNT=10'h3FF, PC_INC=1 -> PC_COUNT=0 next cycle (wrap).
- CALL: PC_COUNT=0x020, PC_LD=1, sel=00, FROM_IMMED=0x100, PUSH=1, PUSH_SEL=0 -> PC_COUNT=0x100, STACK_TOP=0x021, STACK_CNT=1. Then RET (PC_LD, sel=01, POP) -> PC_COUNT=0x021, STACK_EMPTY=1.
- Interrupt: PC_COUNT=0x055, PC_LD=1, sel=10, PUSH=1, PUSH_SEL=1 -> PC_COUNT=0x3FF, STACK_TOP=0x055. Nested CALL then two RETs return in LIFO order.
- Overflow: 9 pushes of distinct values at STACK_DEPTH=8 -> after 8 pushes STACK_FULL=1. 9th push leaves STACK_TOP unchanged and sets STACK_ERR=1. 8 pops return the values in reverse; a 9th pop keeps STACK_CNT=0 and STACK_TOP=0.
- RST asserted with PUSH=1, PC_LD=1 and a non-empty stack -> STACK_CNT=0, PC_COUNT=RESET_ADDR, STACK_ERR=0. Separately, PUSH and POP together on a stack with CNT=3 -> CNT stays 3, top replaced.
